// File: rtl/psc_trigger_receiver.sv
// PSC trigger link receiver: oversamples the serial line, recovers start/8-data/stop
// characters, reassembles CRC-8 protected frames and pulses trigger_out on trigger frames.
module psc_trigger_receiver #(
    parameter int          CLKS_PER_BIT = 5,
    parameter int          FRAME_LEN    = 16,
    parameter logic [7:0]  TRIG_CMD     = 8'hA5,
    parameter int          TIMEOUT_CLKS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       psc_input,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_done,
    output logic       trigger_out,
    output logic       crc_error,
    output logic       framing_error,
    output logic       timeout_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [7:0]  BIT_FULL = 8'(CLKS_PER_BIT);
    localparam logic [7:0]  BIT_HALF = 8'(CLKS_PER_BIT / 2);
    localparam logic [3:0]  IDX_LAST = 4'(FRAME_LEN - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CLKS - 1);

    // CRC-8, poly 0x07, MSB first, whole byte folded in one step
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic       sync1_r, sync2_r, sync3_r;
    logic       fall_s;
    state_t     state_r;
    logic [7:0] bit_cnt_r;
    logic [2:0] bit_idx_r;
    logic [7:0] shift_r;
    logic [3:0] frame_idx_r;
    logic [7:0] crc_r;
    logic [7:0] cmd_r;
    logic [15:0] to_cnt_r;
    logic [7:0] rx_byte_r;
    logic       rx_byte_valid_r, frame_done_r, trigger_out_r;
    logic       crc_error_r, framing_error_r, timeout_error_r;

    assign fall_s = sync3_r & ~sync2_r;

    // Two-stage synchronizer plus a history stage for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            sync3_r <= 1'b1;
        end else begin
            sync1_r <= psc_input;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Bit FSM, frame assembly, CRC check, idle timeout and registered pulse outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            bit_cnt_r       <= 8'd0;
            bit_idx_r       <= 3'd0;
            shift_r         <= 8'd0;
            frame_idx_r     <= 4'd0;
            crc_r           <= 8'd0;
            cmd_r           <= 8'd0;
            to_cnt_r        <= 16'd0;
            rx_byte_r       <= 8'd0;
            rx_byte_valid_r <= 1'b0;
            frame_done_r    <= 1'b0;
            trigger_out_r   <= 1'b0;
            crc_error_r     <= 1'b0;
            framing_error_r <= 1'b0;
            timeout_error_r <= 1'b0;
        end else begin
            rx_byte_valid_r <= 1'b0;
            frame_done_r    <= 1'b0;
            trigger_out_r   <= 1'b0;
            crc_error_r     <= 1'b0;
            framing_error_r <= 1'b0;
            timeout_error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= BIT_HALF;
                    bit_idx_r <= 3'd0;
                    if (fall_s) begin
                        state_r  <= ST_START;
                        to_cnt_r <= 16'd0;
                    end else if (frame_idx_r != 4'd0) begin
                        if (to_cnt_r == TO_LAST) begin
                            timeout_error_r <= 1'b1;
                            frame_idx_r     <= 4'd0;
                            crc_r           <= 8'd0;
                            to_cnt_r        <= 16'd0;
                        end else begin
                            to_cnt_r <= to_cnt_r + 16'd1;
                        end
                    end else begin
                        to_cnt_r <= 16'd0;
                    end
                end
                ST_START: begin
                    if (bit_cnt_r == 8'd1) begin
                        // A line seen high at mid start bit is a glitch, not a character
                        if (!sync2_r) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= BIT_FULL;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 8'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == 8'd1) begin
                        shift_r   <= {sync2_r, shift_r[7:1]};
                        bit_cnt_r <= BIT_FULL;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 8'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_cnt_r == 8'd1) begin
                        state_r <= ST_IDLE;
                        if (!sync2_r) begin
                            framing_error_r <= 1'b1;
                            frame_idx_r     <= 4'd0;
                            crc_r           <= 8'd0;
                        end else if (frame_idx_r != IDX_LAST) begin
                            rx_byte_r       <= shift_r;
                            rx_byte_valid_r <= 1'b1;
                            crc_r           <= crc8_update(crc_r, shift_r);
                            frame_idx_r     <= frame_idx_r + 4'd1;
                            if (frame_idx_r == 4'd0) begin
                                cmd_r <= shift_r;
                            end else begin
                                cmd_r <= cmd_r;
                            end
                        end else begin
                            // The CRC byte is consumed by the check and not presented on rx_byte
                            if (shift_r == crc_r) begin
                                frame_done_r  <= 1'b1;
                                trigger_out_r <= (cmd_r == TRIG_CMD);
                            end else begin
                                crc_error_r <= 1'b1;
                            end
                            frame_idx_r <= 4'd0;
                            crc_r       <= 8'd0;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_byte       = rx_byte_r;
    assign rx_byte_valid = rx_byte_valid_r;
    assign frame_done    = frame_done_r;
    assign trigger_out   = trigger_out_r;
    assign crc_error     = crc_error_r;
    assign framing_error = framing_error_r;
    assign timeout_error = timeout_error_r;

endmodule

// File: tb/tb_psc_trigger_receiver.sv
// Scoreboard bench for psc_trigger_receiver: a frame-level model predicts output events,
// a monitor compares every pulse the DUT produces against the predicted queue.
module tb_psc_trigger_receiver;

    localparam int         C   = 5;
    localparam int         FL  = 10;
    localparam int         TO  = 100;
    localparam logic [7:0] TC  = 8'h31;

    // event flags: {rx_byte_valid, frame_done, trigger_out, crc_error, framing_error, timeout_error}
    typedef struct packed {
        logic [5:0] flags;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       psc_input = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_byte_valid, frame_done, trigger_out, crc_error, framing_error, timeout_error;

    int   tests = 0;
    int   fails = 0;
    int   events_seen = 0;
    ev_t  exp_q[$];
    logic [7:0] fb_m[16];
    int   fn_m = 0;
    logic [5:0] obs;
    ev_t  exp_e;

    always #10 clk = ~clk;

    psc_trigger_receiver #(
        .CLKS_PER_BIT(C),
        .FRAME_LEN(FL),
        .TRIG_CMD(TC),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .psc_input(psc_input),
        .rx_byte(rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .frame_done(frame_done),
        .trigger_out(trigger_out),
        .crc_error(crc_error),
        .framing_error(framing_error),
        .timeout_error(timeout_error)
    );

    // Bit-serial CRC-8 (poly 0x07) over the first n bytes, message bits MSB first
    function automatic logic [7:0] crc_of(input logic [7:0] b[16], input int n);
        logic [7:0] crc;
        logic       fbk;
        crc = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                fbk = crc[7] ^ b[k][i];
                crc = {crc[6:0], 1'b0};
                if (fbk) crc = crc ^ 8'h07;
            end
        end
        return crc;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic expect_ev(input logic [5:0] f, input logic [7:0] d);
        ev_t e;
        e.flags = f;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // Frame-level model: decides what one transmitted character must produce
    task automatic model_byte(input logic [7:0] d, input bit stop_ok);
        if (!stop_ok) begin
            expect_ev(6'b000010, 8'h00);
            fn_m = 0;
        end else if (fn_m < FL - 1) begin
            expect_ev(6'b100000, d);
            fb_m[fn_m] = d;
            fn_m++;
        end else begin
            if (d == crc_of(fb_m, fn_m)) begin
                expect_ev((fb_m[0] == TC) ? 6'b011000 : 6'b010000, 8'h00);
            end else begin
                expect_ev(6'b000100, 8'h00);
            end
            fn_m = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int gap);
        model_byte(d, stop_ok);
        psc_input = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            psc_input = d[i];
            repeat (C) @(negedge clk);
        end
        psc_input = stop_ok;
        repeat (C) @(negedge clk);
        psc_input = 1'b1;
        if (!stop_ok) repeat (C) @(negedge clk);
        repeat (gap) @(negedge clk);
    endtask

    task automatic long_idle();
        if (fn_m != 0) begin
            expect_ev(6'b000001, 8'h00);
            fn_m = 0;
        end
        psc_input = 1'b1;
        repeat (TO + 50) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input bit corrupt);
        logic [7:0] b[16];
        logic [7:0] c;
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        b[0] = cmd;
        for (int i = 1; i < FL - 1; i++) b[i] = 8'($urandom);
        c = crc_of(b, FL - 1);
        if (corrupt) c = c ^ 8'(1 << $urandom_range(0, 7));
        b[FL-1] = c;
        for (int i = 0; i < FL; i++) send_byte(b[i], 1'b1, $urandom_range(0, 15));
    endtask

    task automatic glitch();
        psc_input = 1'b0;
        repeat (2) @(negedge clk);
        psc_input = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_byte"}, 32'(rx_byte), 32'h0);
        check({tag, "_pulses"}, 32'({rx_byte_valid, frame_done, trigger_out, crc_error,
                                     framing_error, timeout_error}), 32'h0);
    endtask

    // Monitor: every output pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset) begin
            obs = {rx_byte_valid, frame_done, trigger_out, crc_error, framing_error, timeout_error};
            if (obs != 6'b0) begin
                events_seen++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got flags %b data %02h expected none", obs, rx_byte);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (obs != exp_e.flags || (obs[5] && rx_byte != exp_e.data)) begin
                        fails++;
                        $display("FAIL event: got flags %b data %02h expected flags %b data %02h",
                                 obs, rx_byte, exp_e.flags, exp_e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] v[16];
        int e0;
        int r;

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Reference vector "123456789" -> 0xF4, byte 0 is the trigger command
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), 1'b1, 0);
        send_byte(8'hF4, 1'b1, 6);
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), 1'b1, 0);
        send_byte(8'hF5, 1'b1, 6);

        send_frame(8'h5A, 1'b0);

        // Framing error on byte 3, then a clean frame
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 2);
        send_byte(8'h3C, 1'b0, 2);
        send_frame(TC, 1'b0);

        e0 = events_seen;
        glitch();
        repeat (60) @(negedge clk);
        check("glitch_events", 32'(events_seen), 32'(e0));
        check("glitch_queue", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 3);
        long_idle();
        send_frame(TC, 1'b0);

        // Reset in the middle of byte 5
        v[0] = TC; v[1] = 8'h11; v[2] = 8'h22; v[3] = 8'h33;
        for (int i = 0; i < 4; i++) send_byte(v[i], 1'b1, 1);
        psc_input = 1'b0;
        repeat (3 * C) @(negedge clk);
        reset = 1'b1;
        psc_input = 1'b1;
        exp_q.delete();
        fn_m = 0;
        #1;
        check_all_zero("mid_frame_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(TC, 1'b0);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                send_frame(($urandom_range(0, 1) == 1) ? TC : 8'($urandom),
                           ($urandom_range(0, 3) == 0));
            end else if (r == 6) begin
                send_byte(8'($urandom), 1'b0, $urandom_range(0, 10));
            end else if (r == 7) begin
                for (int i = 0; i < $urandom_range(1, 5); i++)
                    send_byte(8'($urandom), 1'b1, $urandom_range(0, 15));
                long_idle();
            end else if (r == 8) begin
                send_byte(8'($urandom), 1'b1, $urandom_range(0, 15));
            end else begin
                glitch();
            end
        end

        long_idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psc_trigger_receiver.md
# psc_trigger_receiver

Serial receiver for the PSC trigger link: the far-end counterpart of the PSC trigger transmitter. It oversamples the 10 Mbit/s serial line in the 50 MHz system clock domain and recovers 10-bit characters (start, 8 data bits, stop). It reassembles fixed-length frames, checks the trailing CRC-8, and emits a single-cycle `trigger_out` pulse when a valid trigger frame arrives. It sits at the power-supply-controller end of the fibre/copper link and feeds local trigger logic and diagnostics counters.

## Interface
- `CLKS_PER_BIT`, default 5: clk cycles per serial bit (50 MHz / 10 Mbit/s); legal range 4..255.
- `FRAME_LEN`, default 16: bytes per frame including the trailing CRC byte; legal range 2..16.
- `TRIG_CMD`, default 8'hA5: value of byte 0 that marks a trigger frame.
- `TIMEOUT_CLKS`, default 100: idle clk cycles mid-frame before the partial frame is discarded.
- `clk` input 1: system clock, 50 MHz; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `psc_input` input 1: serial line, asynchronous to `clk`; idles high.
- `rx_byte` output 8: last received data byte; holds its value until the next byte.
- `rx_byte_valid` output 1: one-cycle pulse when `rx_byte` updates.
- `frame_done` output 1: one-cycle pulse when the final byte of a frame is received and the CRC matches.
- `trigger_out` output 1: one-cycle pulse, coincident with `frame_done`, when byte 0 == `TRIG_CMD`.
- `crc_error` output 1: one-cycle pulse when the final byte does not match the CRC.
- `framing_error` output 1: one-cycle pulse when a stop bit is sampled low.
- `timeout_error` output 1: one-cycle pulse when a partial frame is discarded by timeout.

## Operation
- **Input synchronizer:** 2-FF synchronizer on `psc_input`; a third FF is used for edge detection. The synchronizer FFs reset to 1.
- **Bit FSM states:** IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge (previous 1, current 0). A bit counter is loaded with `CLKS_PER_BIT/2` (floor).
  - START: on counter expiry, sample the line. If 0, go to DATA and reload the counter with `CLKS_PER_BIT`. If 1, it is a false start: return to IDLE with no error.
  - DATA: sample at each `CLKS_PER_BIT` expiry. There are 8 samples, LSB first, shifted into the byte register. Go to STOP after the 8th.
  - STOP: sample after `CLKS_PER_BIT`.
    - Sample 1: byte accepted.
    - Sample 0: pulse `framing_error`, discard the byte, and reset the frame index to 0.
    - Either way, return to IDLE in the same cycle. The next falling edge is detectable immediately, so back-to-back characters are supported.
- **Frame layer:**
  - Byte index 0..`FRAME_LEN`-1 and a CRC register.
  - On each accepted byte with index < `FRAME_LEN`-1: update the CRC, store byte 0 into a command register when index == 0, and increment the index.
  - On index == `FRAME_LEN`-1: compare the accepted byte with the CRC register. On a match, pulse `frame_done`, plus `trigger_out` if the command == `TRIG_CMD`. On a mismatch, pulse `crc_error`. In both cases the index resets to 0 and the CRC resets to 0x00.
- **CRC-8:**
  - Polynomial 0x07 (x^8+x^2+x+1), init 0x00, MSB-first processing, no reflection, no final XOR.
  - The update is combinational over the full byte in one cycle.
  - Width rule: 8-bit register, with the result truncated to 8 bits each step.
- **Timeout:**
  - A counter runs while the FSM is in IDLE and the index is nonzero, and clears on each falling edge.
  - On reaching `TIMEOUT_CLKS`: pulse `timeout_error`, reset the index to 0 and the CRC to 0x00.
  - The counter saturates and does not run while the index is 0.
- **Simultaneous events:** at most one of `frame_done`, `crc_error`, `framing_error`, `timeout_error` pulses in a given cycle. A timeout cannot coincide with a stop sample because the FSM is not in IDLE during a stop sample.

## Timing
- **Reset:** all outputs are 0, `rx_byte` = 0x00, FSM in IDLE, index 0, CRC 0x00, command register 0x00. Reset mid-character or mid-frame discards everything. The first frame after reset release must begin with a fresh start bit.
- **Input latency:** 2 clk cycles from a `psc_input` transition to the synchronized value, plus 1 cycle for edge detection.
- **Output latency:** `rx_byte_valid`, `frame_done`, `trigger_out`, `crc_error` and `framing_error` assert exactly 1 clk after the cycle in which the stop bit is sampled (registered outputs).
- **Sample points:** the stop bit is sampled at 9.5 × `CLKS_PER_BIT` (floored) cycles after the detected start edge, ±1 cycle of synchronizer uncertainty.
- **Pulse width:** every pulse output is high for exactly 1 clk.

## Test plan
- **CRC vector:** `FRAME_LEN`=10, `TRIG_CMD`=8'h31; send bytes 0x31..0x39 then 0xF4 back-to-back -> nine `rx_byte_valid` pulses, then `frame_done` and `trigger_out` pulse together once; `crc_error` stays 0.
- **Non-trigger frame:** same frame with `TRIG_CMD`=8'hA5 -> `frame_done` pulses, `trigger_out` stays 0. Last byte changed to 0xF5 -> `crc_error` pulses, no `frame_done`.
- **Framing error:** stop bit driven 0 on byte 3 -> `framing_error` pulse. A following complete valid frame must then produce `frame_done` (index was reset).
- **Glitch rejection:** a low glitch of 2 clk cycles on an idle line -> no `rx_byte_valid` and no errors.
- **Timeout:** send 4 bytes, then hold the line high for 150 clk cycles -> `timeout_error` pulses once at 100 idle cycles. A following valid frame is accepted.
- **Reset:** assert `reset` mid-byte 5 -> all outputs 0 immediately. After release, a full valid trigger frame produces exactly one `trigger_out`.
